ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit words; power of two.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..15, wait cycles inserted per OKAY data phase.
REQ-005 SHALL have ports: hclk in 1 clock; hresetn in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: hselx in 1 slave select; haddr in ADDR_WIDTH; htrans in 2; hwrite in 1; hsize in 3; hburst in 3; hprot in 4; hmastlock in 1.
REQ-007 SHALL have ports: hwdata in 32 write data; hready in 1 bus-level ready.
REQ-008 SHALL have ports: hreadyout out 1; hresp out 2 (00 OKAY, 01 ERROR); hrdata out 32.
REQ-009 Reset SHALL be hresetn, asynchronous, active-low; the clock SHALL be hclk.

Function
REQ-010 An address phase SHALL be accepted on a rising hclk edge where hselx=1, hready=1 and htrans is NONSEQ(10) or SEQ(11).
REQ-011 IDLE(00) or BUSY(01) with hselx=1 SHALL get a zero-wait OKAY data phase with no memory access.
REQ-012 An accepted phase SHALL be registered: word address haddr[log2(MEM_DEPTH)+1:2], byte offset haddr[1:0], hsize, hwrite.
REQ-013 The FSM SHALL have states IDLE, WAIT, ERR1 and ERR2.
REQ-014 IDLE->WAIT SHALL occur on a legal accepted phase with WAIT_STATES>0; IDLE->ERR1 SHALL occur on an illegal phase; otherwise the FSM SHALL stay in IDLE with a zero-wait completion.
REQ-015 In WAIT, hreadyout SHALL be 0 for exactly WAIT_STATES cycles, using a down-counter of width clog2(WAIT_STATES+1); hreadyout SHALL be 1 in the following cycle.
REQ-016 An illegal phase SHALL be hsize>2, or haddr misaligned to hsize (halfword: haddr[0]=1; word: haddr[1:0]!=0).
REQ-017 An error response SHALL be ERR1: hresp=01, hreadyout=0; then ERR2: hresp=01, hreadyout=1; then IDLE.
REQ-018 An address phase presented during ERR1 SHALL be ignored; one presented during ERR2 SHALL be accepted normally.
REQ-019 A write SHALL commit on the edge that completes its data phase, using byte lanes from hsize and offset, with hwdata sampled on that edge.
REQ-020 Read hrdata SHALL be mem[word address] while a read data phase is active, and 0 otherwise; the full word SHALL be returned.
REQ-021 A write followed by a read of the same address in back-to-back phases SHALL return the new data with no stall.
REQ-022 A new address phase SHALL be accepted on the same edge that completes the previous data phase (pipelined).
REQ-023 hburst, hprot and hmastlock SHALL be accepted and ignored; bursts SHALL be handled as independent beats.
REQ-024 The word address SHALL wrap modulo MEM_DEPTH unless the feature in REQ-029 is enabled.

Reset
REQ-025 On reset, hreadyout SHALL be 1, hresp 00, hrdata 0, the FSM IDLE, the counter 0 and the captured phase invalid.
REQ-026 Reset asserted mid-data-phase SHALL abort the transfer and SHALL NOT commit the write.
REQ-027 Memory contents SHALL NOT be reset.

Configuration
REQ-028 Macro AHB_SRAM_OOR_ERR_EN SHALL control out-of-range checking.
REQ-029 With AHB_SRAM_OOR_ERR_EN defined, any haddr >= 4*MEM_DEPTH SHALL be illegal and take the ERR1/ERR2 path with no memory access.
REQ-030 Without AHB_SRAM_OOR_ERR_EN, the upper address bits SHALL be ignored and the address SHALL wrap per REQ-024.

Structure
REQ-031 The htrans, hresp and hsize encodings and the FSM state enum SHALL live in AhbGlobalPackage.
REQ-032 The byte-lane RAM array SHALL be the sub-module ahb_sram_mem: one write port with 4-bit byte enables and one asynchronous read port.

Verification
REQ-033 Word write 0xDEADBEEF @0x10, then read @0x10, WAIT_STATES=0: hreadyout stays 1 and hrdata=0xDEADBEEF in the second data phase.
REQ-034 WAIT_STATES=3, read @0x4: hreadyout is low for exactly 3 cycles, then high with the data.
REQ-035 Byte write 0xAA @0x21 over word 0x11223344: reading @0x20 returns 0x1122AA44.
REQ-036 Halfword access @0x3: ERR1 (hresp=01, hreadyout=0), then ERR2 (hresp=01, hreadyout=1), memory unchanged, next NONSEQ OKAY.
REQ-037 With AHB_SRAM_OOR_ERR_EN, access @0x1000 with MEM_DEPTH=1024 gives a two-cycle ERROR; without the macro it aliases to @0x0.
REQ-038 hresetn deasserted during WAIT of a write: after reset, outputs equal reset values and the target word keeps its old value.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// ahb_sram_slave_pkg: AHB encodings, slave FSM states and byte-lane helper shared by the SRAM slave
package AhbGlobalPackage;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;
  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;
  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;
  function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] off);
    lane_en = size == HSIZE_WORD ? 4'b1111 : size == HSIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
  endfunction
endpackage

// File: rtl/ahb_sram_slave_mem.sv
// ahb_sram_mem: byte-lane word RAM with one byte-enabled write port and one asynchronous read port
module ahb_sram_mem #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          hclk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [3:0][7:0] mem [DEPTH];
  // Byte-lane write; contents are never reset
  always_ff @(posedge hclk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[waddr][i] <= wdata[8*i +: 8];
  assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with configurable wait states; define AHB_SRAM_OOR_ERR_EN to answer out-of-range addresses with ERROR
module ahb_sram_slave
  import AhbGlobalPackage::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic ph_valid, ph_write, accept, illegal, oor, we, unused_ok;
  logic [AW-1:0] ph_addr;
  logic [1:0] ph_off;
  logic [2:0] ph_size;
  logic [31:0] rd_word;
  assign unused_ok = ^{hburst, hprot, hmastlock, haddr};
`ifdef AHB_SRAM_OOR_ERR_EN
  assign oor = (haddr >> (AW + 2)) != '0;
`else
  assign oor = 1'b0;
`endif
  assign accept = hselx && hready && hreadyout && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign illegal = hsize > HSIZE_WORD || (hsize == HSIZE_HALF && haddr[0]) || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00) || oor;
  assign we = ph_valid && ph_write && hreadyout;
  assign hrdata = ph_valid && !ph_write ? rd_word : '0;
  // Response outputs and next state; a WAIT with the counter at zero is the completing cycle
  always_comb begin
    hreadyout = !(state == ST_ERR1 || (state == ST_WAIT && cnt != '0));
    hresp = state == ST_ERR1 || state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
    state_nx = ST_IDLE;
    cnt_nx = '0;
    if (!hreadyout) begin
      state_nx = state == ST_ERR1 ? ST_ERR2 : ST_WAIT;
      cnt_nx = state == ST_WAIT ? cnt - 1'b1 : '0;
    end else if (accept) begin
      state_nx = illegal ? ST_ERR1 : (WAIT_STATES > 0 ? ST_WAIT : ST_IDLE);
      cnt_nx = illegal ? '0 : CW'(WAIT_STATES);
    end
  end
  // FSM state and wait-state down-counter
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // Register the address phase on each edge that completes the current data phase
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_addr <= '0;
      ph_off <= '0;
      ph_size <= '0;
    end else if (hreadyout) begin
      ph_valid <= accept && !illegal;
      ph_write <= hwrite;
      ph_addr <= haddr[AW+1:2];
      ph_off <= haddr[1:0];
      ph_size <= hsize;
    end
  ahb_sram_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
    .hclk  (hclk),
    .we    (we),
    .be    (lane_en(ph_size, ph_off)),
    .waddr (ph_addr),
    .wdata (hwdata),
    .raddr (ph_addr),
    .rdata (rd_word)
  );
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: scoreboard bench driving one slave at zero and one at three wait states
module tb_ahb_sram_slave;
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          low;
  } exp_t;
  logic hclk = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 hclk = ~hclk;
  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s ws=%0d got %h want %h at %0t", nm, inst, act, req, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int WS = g ? 3 : 0;
    logic hresetn = 1'b1;
    logic hselx, hwrite, hmastlock, hready, hreadyout;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0] htrans, hresp;
    logic [2:0] hsize, hburst;
    logic [3:0] hprot;
    logic [31:0] mdl [1024];
    exp_t q[$];
    bit done = 0;
    logic [31:0] a;
    logic [2:0] sz;
    logic [1:0] off, tr;
    ahb_sram_slave #(.WAIT_STATES(WS)) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hselx     (hselx),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (hburst),
      .hprot     (hprot),
      .hmastlock (hmastlock),
      .hwdata    (hwdata),
      .hready    (hready),
      .hreadyout (hreadyout),
      .hresp     (hresp),
      .hrdata    (hrdata)
    );
    assign hready = hreadyout;
    task automatic expect_txn(input logic wr, input logic [31:0] ad, input logic [2:0] s, input logic [31:0] wd);
      int idx;
      bit bad;
      idx = int'((ad / 4) % 1024);
      bad = s > 2 || (ad % (32'd1 << s)) != 0;
`ifdef AHB_SRAM_OOR_ERR_EN
      bad = bad || ad >= 32'd4096;
`endif
      if (bad) q.push_back('{2'b01, 32'h0, 1});
      else begin
        q.push_back('{2'b00, wr ? 32'h0 : mdl[idx], WS});
        if (wr)
          for (int b = 0; b < 4; b++)
            if (b >= int'(ad % 4) && b < int'(ad % 4) + (1 << s)) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end
    endtask
    task automatic issue(input logic sel, input logic [1:0] t, input logic wr, input logic [31:0] ad, input logic [2:0] s, input logic [31:0] wd);
      int n;
      n = 0;
      while (!hready && n < 64) begin
        @(posedge hclk);
        #1;
        n++;
      end
      if (n >= 64) begin
        checks++;
        errors++;
        $display("FAIL hready_timeout ws=%0d got %b want 1", WS, hready);
      end
      hselx = sel;
      htrans = t;
      hwrite = wr;
      haddr = ad;
      hsize = s;
      hburst = 3'($urandom);
      hprot = 4'($urandom);
      hmastlock = 1'($urandom);
      if (sel && t[1]) expect_txn(wr, ad, s, wd);
      @(posedge hclk);
      #1;
      hwdata = wd;
    endtask
    task automatic wait_idle();
      int n;
      n = 0;
      issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
      while (q.size() != 0 && n < 100) begin
        @(posedge hclk);
        #1;
        n++;
      end
      check("drain", WS, q.size(), 0);
    endtask
    initial begin
      hselx = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0;
      hburst = 0; hprot = 0; hmastlock = 0; hwdata = 0;
      #1 hresetn = 1'b0;
      #2;
      check("reset_hreadyout", WS, 32'(hreadyout), 32'd1);
      check("reset_hresp", WS, 32'(hresp), 32'd0);
      check("reset_hrdata", WS, hrdata, 32'd0);
      @(negedge hclk);
      @(negedge hclk);
      #1 hresetn = 1'b1;
      @(posedge hclk);
      #1;
      for (int w = 0; w < 16; w++) issue(1, 2'b10, 1, 32'(w * 4), 3'd2, $urandom);
      issue(1, 2'b10, 1, 32'h10, 3'd2, 32'hDEADBEEF);
      issue(1, 2'b10, 0, 32'h10, 3'd2, $urandom);
      issue(1, 2'b10, 1, 32'h20, 3'd2, 32'h11223344);
      issue(1, 2'b11, 1, 32'h21, 3'd0, 32'h0000AA00);
      issue(1, 2'b11, 0, 32'h20, 3'd2, 32'h0);
      issue(1, 2'b10, 1, 32'h3, 3'd1, 32'hFFFFFFFF);
      issue(1, 2'b10, 0, 32'h0, 3'd2, 32'h0);
      issue(1, 2'b10, 0, 32'h4, 3'd2, 32'h0);
      issue(1, 2'b10, 0, 32'h1000, 3'd2, 32'h0);
      issue(1, 2'b10, 1, 32'h1008, 3'd2, 32'hCAFE0001);
      issue(1, 2'b10, 0, 32'h8, 3'd2, 32'h0);
      issue(1, 2'b10, 0, 32'h8, 3'd3, 32'h0);
      issue(1, 2'b10, 1, 32'h6, 3'd2, 32'h12345678);
      issue(1, 2'b00, 0, 32'h8, 3'd2, 32'h0);
      issue(1, 2'b01, 0, 32'h8, 3'd2, 32'h0);
      issue(1, 2'b10, 1, 32'h1A, 3'd1, 32'hBEEF0000);
      issue(1, 2'b10, 0, 32'h18, 3'd2, 32'h0);
      wait_idle();
      hselx = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h14; hsize = 3'd2;
      q.push_back('{2'b00, 32'h0, WS});
      @(posedge hclk);
      #1;
      hwdata = ~mdl[5];
      hselx = 0;
      htrans = 2'b00;
      if (WS > 0) begin
        @(posedge hclk);
        #1;
      end
      hresetn = 1'b0;
      q.delete();
      #1;
      check("abort_hreadyout", WS, 32'(hreadyout), 32'd1);
      check("abort_hresp", WS, 32'(hresp), 32'd0);
      check("abort_hrdata", WS, hrdata, 32'd0);
      @(negedge hclk);
      #1 hresetn = 1'b1;
      @(posedge hclk);
      #1;
      issue(1, 2'b10, 0, 32'h14, 3'd2, 32'h0);
      for (int i = 0; i < 250; i++) begin
        sz = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        off = 2'($urandom);
        if ($urandom_range(0, 3) != 0 && sz <= 3'd2) off = 2'((off >> sz) << sz);
        a = ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 255)) << 12 : 32'h0) | 32'($urandom_range(0, 15) << 2) | 32'(off);
        tr = $urandom_range(0, 4) == 0 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        issue(1'($urandom_range(0, 9) != 0), tr, 1'($urandom), a, sz, $urandom);
      end
      wait_idle();
      done = 1;
    end
    initial begin
      bit act;
      int low;
      exp_t e;
      act = 0;
      low = 0;
      forever begin
        @(negedge hclk);
        if (!hresetn) act = 0;
        else begin
          if (act && q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow ws=%0d got data phase want none at %0t", WS, $time);
            act = 0;
          end else if (act && !hreadyout) begin
            low++;
            check("wait_hresp", WS, 32'(hresp), 32'(q[0].resp));
          end else if (act) begin
            e = q.pop_front();
            check("hresp", WS, 32'(hresp), 32'(e.resp));
            check("hrdata", WS, hrdata, e.rdata);
            check("wait_cycles", WS, low, e.low);
            act = 0;
          end else begin
            check("idle_hreadyout", WS, 32'(hreadyout), 32'd1);
            check("idle_hresp", WS, 32'(hresp), 32'd0);
            check("idle_hrdata", WS, hrdata, 32'd0);
          end
          if (hselx && hready && htrans[1]) begin
            act = 1;
            low = 0;
          end
        end
      end
    end
  end
  initial begin
    wait (g_inst[0].done && g_inst[1].done);
    repeat (2) @(posedge hclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want done by %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
